pipemem_arb: RTL and testbench
==============================

# pipemem_arb

Single-port memory arbiter for the five-stage pipeline. It shares one synchronous, single-port 32-bit RAM between two requesters: the instruction fetch port (IF) and the data port (MEM stage). The data port has fixed priority. A starvation counter guarantees IF forward progress. Each granted access completes with a one-cycle `*_ack` pulse, which the pipeline uses as its advance/stall condition.

## Interface
- `AW`, default 8: RAM word-address width; the RAM holds 2^AW words.
- `MAXWAIT`, default 3: number of consecutive IF losses to the data port before IF is forced to win. Legal range is 1..15.

- `clock`  in  1: rising-edge clock
- `resetn`  in  1: reset, asynchronous, active-low
- `if_req`  in  1: IF read request; held until `if_ack`
- `if_addr`  in  32: IF byte address
- `if_rdata`  out  32: instruction word; valid only while `if_ack`
- `if_ack`  out  1: one-cycle completion pulse for IF
- `dm_req`  in  1: data request; held until `dm_ack`
- `dm_we`  in  1: 1 = write, 0 = read
- `dm_addr`  in  32: data byte address
- `dm_wdata`  in  32: write data
- `dm_rdata`  out  32: load data; valid only while `dm_ack` of a read
- `dm_ack`  out  1: one-cycle completion pulse for the data port
- `ram_we`  out  1: RAM write enable
- `ram_addr`  out  AW: RAM word address
- `ram_wdata`  out  32: RAM write data
- `ram_rdata`  in  32: RAM read data; valid the cycle after the address is presented
- `grant_if`  out  1: IF access issued this cycle
- `grant_dm`  out  1: data access issued this cycle

## Operation
- **Issue.** At most one access is issued per cycle, combinationally from the sampled `*_req`.
  - In the issue cycle the arbiter drives `ram_addr` = `addr[AW+1:2]`.
  - For a write it also drives `ram_we` = 1 and `ram_wdata` = `dm_wdata`.
  - Address bits `[1:0]` and bits above `AW+1` are ignored, so addresses wrap modulo 2^AW words.
- **Arbitration.**
  - Only `dm_req`: data wins.
  - Only `if_req`: IF wins.
  - Both: data wins, unless `wait_cnt` == `MAXWAIT`, in which case IF wins.
- **Starvation counter `wait_cnt`** (4-bit):
  - Increments in each cycle where `if_req` is high and data is granted.
  - Clears on any IF grant, or in any cycle where `if_req` is low.
  - Saturates at `MAXWAIT`.
- **Response FSM**, registered, with states `IDLE`, `RSP_IF`, `RSP_DM`.
  - Next state is `RSP_IF` after an IF issue, `RSP_DM` after a data issue, otherwise `IDLE`.
  - In `RSP_IF`: `if_ack` = 1 and `if_rdata` = `ram_rdata`.
  - In `RSP_DM`: `dm_ack` = 1; for a read, `dm_rdata` = `ram_rdata`. The read/write flag is registered at issue.
- **Back-to-back requests.** `*_req` high in its own ack cycle is a new request and is eligible for issue in that same cycle. This sustains one access per cycle.
- **Inactive outputs.** Unused outputs are driven to 0: `ram_addr`, `ram_wdata` and `ram_we` when nothing is issued, and `*_rdata` when not acked.
- **Run flag `run_q`.**
  - Cleared by reset and set on the first rising edge after `resetn` rises.
  - While `run_q` = 0, no access is issued.

## Timing
- **Latency.** Request issued in cycle N is acked in cycle N+1, for reads and writes alike.
- **Worst-case IF wait** under continuous data traffic: `MAXWAIT` cycles, then issue.
- **Reset values** (immediately on `resetn` low, and through the first cycle after release):
  - All outputs are 0.
  - FSM = `IDLE`, `wait_cnt` = 0, `run_q` = 0.
- **Reset mid-operation.**
  - An in-flight access is dropped and no ack is produced.
  - `ram_we` is forced low asynchronously, so no partial write occurs after `resetn` falls.
- **Simultaneous events.**
  - An ack to one port and an issue to the other can occur in the same cycle.
  - Both grants are never high together.
- **Protocol violation.** If a requester drops `*_req` before its ack, the access has already completed, the ack is still produced, and the requester ignores it.

## Test plan
- **Reset state:** hold `resetn` = 0 with both reqs high → all outputs 0. Release → no grant in the first cycle, `grant_dm` = 1 in the second.
- **IF read:** RAM[5] = 0x8C010004, `if_req` with `if_addr` = 0x14 → `ram_addr` = 5 in cycle N; `if_ack` = 1 and `if_rdata` = 0x8C010004 in N+1.
- **Write then read:** data write of 0xDEADBEEF to 0x20, then a data read of 0x20 raised in the ack cycle → `ram_we` pulses once; the read acks two cycles after the write issue with 0xDEADBEEF.
- **Starvation:** both reqs continuously high, `MAXWAIT` = 3 → grant pattern DM, DM, DM, IF, DM, DM, DM, IF…; each `if_ack` follows its IF grant by exactly one cycle.
- **Wrap-around:** `AW` = 8, `dm_addr` = 0x404 → `ram_addr` = 1.
- **Mid-write reset:** `resetn` falls during a write issue cycle → `ram_we` drops the same cycle, no `dm_ack` ever appears, and the FSM returns to `IDLE`.

Source files
------------

// File: rtl/pipemem_arb_if.sv
// Bus bundle between the pipeline requesters, the shared RAM and pipemem_arb.
// slave = arbiter side, master = pipeline/RAM side.
interface pipemem_arb_if #(
    parameter int AW = 8
);
    logic          if_req;
    logic [31:0]   if_addr;
    logic [31:0]   if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;
    logic          dm_ack;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          grant_if;
    logic          grant_dm;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack, ram_we, ram_addr, ram_wdata,
               grant_if, grant_dm
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack, ram_we, ram_addr, ram_wdata,
               grant_if, grant_dm
    );
endinterface

// File: rtl/pipemem_arb.sv
// Single-port RAM arbiter: data port has fixed priority, IF is forced through
// after MAXWAIT consecutive losses. Every issued access is acked one cycle later.
module pipemem_arb #(
    parameter int AW      = 8,
    parameter int MAXWAIT = 3
) (
    input  logic          clock,
    input  logic          resetn,
    pipemem_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSP_IF = 2'd1,
        RSP_DM = 2'd2
    } state_t;

    localparam logic [3:0] MAXW = 4'(MAXWAIT);

    state_t      state;
    logic        run_q;
    logic        we_q;
    logic [3:0]  wait_cnt;
    logic        gnt_if;
    logic        gnt_dm;
    logic [31:0] sel_addr;
    logic        unused_addr_bits;

    // Both grants depend on run_q, so an asynchronous reset drops ram_we at once.
    always_comb begin
        gnt_dm = run_q && bus.dm_req && !(bus.if_req && (wait_cnt == MAXW));
        gnt_if = run_q && bus.if_req && !gnt_dm;
    end

    assign sel_addr      = gnt_dm ? bus.dm_addr : bus.if_addr;
    assign bus.grant_dm  = gnt_dm;
    assign bus.grant_if  = gnt_if;
    assign bus.ram_addr  = (gnt_dm || gnt_if) ? sel_addr[AW+1:2] : '0;
    assign bus.ram_we    = gnt_dm && bus.dm_we;
    assign bus.ram_wdata = (gnt_dm && bus.dm_we) ? bus.dm_wdata : '0;

    assign bus.if_ack    = (state == RSP_IF);
    assign bus.if_rdata  = (state == RSP_IF) ? bus.ram_rdata : '0;
    assign bus.dm_ack    = (state == RSP_DM);
    assign bus.dm_rdata  = (state == RSP_DM && !we_q) ? bus.ram_rdata : '0;

    assign unused_addr_bits = &{1'b0, bus.if_addr[31:AW+2], bus.if_addr[1:0],
                                bus.dm_addr[31:AW+2], bus.dm_addr[1:0]};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            run_q    <= 1'b0;
            state    <= IDLE;
            we_q     <= 1'b0;
            wait_cnt <= '0;
        end else begin
            run_q <= 1'b1;
            we_q  <= gnt_dm && bus.dm_we;
            if (gnt_if)
                state <= RSP_IF;
            else if (gnt_dm)
                state <= RSP_DM;
            else
                state <= IDLE;

            if (!bus.if_req || gnt_if)
                wait_cnt <= '0;
            else if (gnt_dm && wait_cnt != MAXW)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_pipemem_arb.sv
// Directed bench for pipemem_arb: per-cycle vector table plus hand-written
// starvation and mid-write reset sequences, against a behavioural RAM.
module tb_pipemem_arb;
    logic clock;
    logic resetn;
    int   errors;
    int   checks;

    pipemem_arb_if #(.AW(8)) bus ();

    pipemem_arb #(.AW(8), .MAXWAIT(3)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [31:0] mem [256];

    always @(posedge clock) begin
        if (bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic        gi;
        logic        gd;
        logic        we;
        logic [7:0]  ra;
        logic        iack;
        logic [31:0] ird;
        logic        dack;
        logic [31:0] drd;
    } vec_t;

    vec_t vec [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " grant_if"},  32'(bus.grant_if),  32'(v.gi));
        chk({tag, " grant_dm"},  32'(bus.grant_dm),  32'(v.gd));
        chk({tag, " ram_we"},    32'(bus.ram_we),    32'(v.we));
        chk({tag, " ram_addr"},  32'(bus.ram_addr),  32'(v.ra));
        chk({tag, " ram_wdata"}, bus.ram_wdata,      v.we ? v.dd : 32'h0);
        chk({tag, " if_ack"},    32'(bus.if_ack),    32'(v.iack));
        chk({tag, " if_rdata"},  bus.if_rdata,       v.ird);
        chk({tag, " dm_ack"},    32'(bus.dm_ack),    32'(v.dack));
        chk({tag, " dm_rdata"},  bus.dm_rdata,       v.drd);
    endtask

    task automatic drive(input vec_t v);
        resetn       = v.rst;
        bus.if_req   = v.ir;
        bus.if_addr  = v.ia;
        bus.dm_req   = v.dr;
        bus.dm_we    = v.dw;
        bus.dm_addr  = v.da;
        bus.dm_wdata = v.dd;
    endtask

    initial begin
        vec_t v;
        errors = 0;
        checks = 0;
        for (int unsigned i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1]   = 32'h1111_1111;
        mem[5]   = 32'h8C01_0004;
        mem[255] = 32'hA5A5_0001;
        resetn = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0;
        bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

        //        rst ir ia            dr dw da            dd            gi gd we ra     iack ird           dack drd
        vec[0]  = '{0, 1, 32'h0,       1, 0, 32'h0,        32'h0,        0, 0, 0, 8'h00, 0, 32'h0,        0, 32'h0};
        vec[1]  = '{0, 1, 32'h0,       1, 0, 32'h0,        32'h0,        0, 0, 0, 8'h00, 0, 32'h0,        0, 32'h0};
        vec[2]  = '{1, 1, 32'h0,       1, 0, 32'h0,        32'h0,        0, 0, 0, 8'h00, 0, 32'h0,        0, 32'h0};
        vec[3]  = '{1, 1, 32'h0,       1, 0, 32'h0,        32'h0,        0, 1, 0, 8'h00, 0, 32'h0,        0, 32'h0};
        vec[4]  = '{1, 0, 32'h0,       0, 0, 32'h0,        32'h0,        0, 0, 0, 8'h00, 0, 32'h0,        1, 32'h0};
        vec[5]  = '{1, 1, 32'h14,      0, 0, 32'h0,        32'h0,        1, 0, 0, 8'h05, 0, 32'h0,        0, 32'h0};
        vec[6]  = '{1, 0, 32'h0,       0, 0, 32'h0,        32'h0,        0, 0, 0, 8'h00, 1, 32'h8C010004, 0, 32'h0};
        vec[7]  = '{1, 0, 32'h0,       1, 1, 32'h20,       32'hDEADBEEF, 0, 1, 1, 8'h08, 0, 32'h0,        0, 32'h0};
        vec[8]  = '{1, 0, 32'h0,       1, 0, 32'h20,       32'h0,        0, 1, 0, 8'h08, 0, 32'h0,        1, 32'h0};
        vec[9]  = '{1, 0, 32'h0,       0, 0, 32'h0,        32'h0,        0, 0, 0, 8'h00, 0, 32'h0,        1, 32'hDEADBEEF};
        vec[10] = '{1, 0, 32'h0,       1, 0, 32'h404,      32'h0,        0, 1, 0, 8'h01, 0, 32'h0,        0, 32'h0};
        vec[11] = '{1, 1, 32'hFFFFF3FF, 0, 0, 32'h0,       32'h0,        1, 0, 0, 8'hFF, 0, 32'h0,        1, 32'h11111111};
        vec[12] = '{1, 0, 32'h0,       0, 0, 32'h0,        32'h0,        0, 0, 0, 8'h00, 1, 32'hA5A50001, 0, 32'h0};
        vec[13] = '{1, 0, 32'h0,       0, 0, 32'h0,        32'h0,        0, 0, 0, 8'h00, 0, 32'h0,        0, 32'h0};

        for (int unsigned i = 0; i < 14; i++) begin
            @(posedge clock); #1;
            drive(vec[i]);
            @(negedge clock);
            check_all($sformatf("vec%0d", i), vec[i]);
        end

        // Continuous contention: DM, DM, DM, IF repeating, acks one cycle later.
        for (int unsigned k = 0; k < 12; k++) begin
            v = '{1, 1, 32'h14, 1, 0, 32'h4, 32'h0, 0, 0, 0, 8'h00, 0, 32'h0, 0, 32'h0};
            v.gi   = (k % 4 == 3);
            v.gd   = !v.gi;
            v.ra   = v.gi ? 8'h05 : 8'h01;
            v.iack = (k > 0) && ((k - 1) % 4 == 3);
            v.dack = (k > 0) && !v.iack;
            v.ird  = v.iack ? 32'h8C010004 : 32'h0;
            v.drd  = v.dack ? 32'h11111111 : 32'h0;
            @(posedge clock); #1;
            drive(v);
            @(negedge clock);
            check_all($sformatf("starve%0d", k), v);
        end
        v = '{1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 8'h00, 1, 32'h8C010004, 0, 32'h0};
        @(posedge clock); #1;
        drive(v);
        @(negedge clock);
        check_all("starve_tail", v);

        // Reset falls inside a write issue cycle.
        @(posedge clock); #1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h30; bus.dm_wdata = 32'h12345678;
        #1;
        chk("midrst we_before",  32'(bus.ram_we),   32'h1);
        chk("midrst gdm_before", 32'(bus.grant_dm), 32'h1);
        #1 resetn = 1'b0;
        #1;
        chk("midrst we_after",   32'(bus.ram_we),    32'h0);
        chk("midrst gdm_after",  32'(bus.grant_dm),  32'h0);
        chk("midrst wdata",      bus.ram_wdata,      32'h0);
        chk("midrst addr",       32'(bus.ram_addr),  32'h0);
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("midrst dm_ack%0d", k), 32'(bus.dm_ack), 32'h0);
            chk($sformatf("midrst if_ack%0d", k), 32'(bus.if_ack), 32'h0);
        end
        chk("midrst mem12", mem[12], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
